// File: rtl/aib_cal_pkg.sv
// Shared types and default timing for the DLL tap calibration sequencer.
package aib_cal_pkg;

  localparam int TAP_W_DEF         = 8;
  localparam int TAP_W_MAX         = 16;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int BLANK_CYCLES_DEF  = 2;
  localparam int CLEAR_CYCLES_DEF  = 4;
  localparam int WDOG_CYCLES_DEF   = 4096;
  localparam int MIN_WIN_DEF       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_EVAL,
    ST_CLEAR,
    ST_CENTER,
    ST_FINISH
  } cal_state_e;

  typedef logic [TAP_W_MAX-1:0] cal_lo_t;
  typedef logic [TAP_W_MAX:0]   cal_len_t;

  // Sized for the widest supported tap; narrower instances zero-extend into it.
  typedef struct packed {
    cal_lo_t  lo;
    cal_len_t len;
  } cal_win_t;

endpackage

// File: rtl/aib_dll_tap_cal_if.sv
// Control, status and test-agent signals of the DLL tap calibration sequencer.
interface aib_dll_tap_cal_if
  import aib_cal_pkg::*;
#(
  parameter int TapW = TAP_W_DEF
);
  logic            i_start;
  logic            i_abort;
  logic [TapW-1:0] i_default_tap;
  logic [TapW-1:0] o_dll_tap;
  logic            o_agent_en;
  logic            i_test_pass;
  logic            i_test_fail;
  logic            i_test_timeout;
  logic            o_busy;
  logic            o_done;
  logic            o_fail;
  logic [TapW-1:0] o_win_lo;
  logic [TapW:0]   o_win_len;

  modport master (
    input  i_start, i_abort, i_default_tap,
    input  i_test_pass, i_test_fail, i_test_timeout,
    output o_dll_tap, o_agent_en,
    output o_busy, o_done, o_fail, o_win_lo, o_win_len
  );

  modport slave (
    output i_start, i_abort, i_default_tap,
    output i_test_pass, i_test_fail, i_test_timeout,
    input  o_dll_tap, o_agent_en,
    input  o_busy, o_done, o_fail, o_win_lo, o_win_len
  );
endinterface

// File: rtl/aib_cal_win_track.sv
// Tracks the current and best passing-tap windows and computes the final centre tap.
module aib_cal_win_track
  import aib_cal_pkg::*;
#(
  parameter int TapW   = TAP_W_DEF,
  parameter int MinWin = MIN_WIN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            clr,
  input  logic            step,
  input  logic            step_pass,
  input  logic            commit,
  input  logic [TapW-1:0] tap,
  output logic [TapW-1:0] best_lo,
  output logic [TapW:0]   best_len,
  output logic [TapW-1:0] centre,
  output logic            final_ok,
  output logic            close_ok
);

  localparam int LenW = TapW + 1;

  cal_win_t              cur;
  cal_win_t              best;
  cal_win_t              fin;
  logic [TAP_W_MAX:0]    mid;

  // Strict compare: on equal widths the earlier window is kept.
  always_comb begin
    fin      = (cur.len > best.len) ? cur : best;
    mid      = {1'b0, fin.lo} + ((fin.len - cal_len_t'(1)) >> 1);
    final_ok = (fin.len >= cal_len_t'(MinWin));
    close_ok = (cur.len >= cal_len_t'(MinWin));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clr) begin
      cur  <= '0;
      best <= '0;
    end else if (step) begin
      if (step_pass) begin
        if (cur.len == '0) cur.lo <= cal_lo_t'(tap);
        cur.len <= cur.len + cal_len_t'(1);
      end else begin
        if (cur.len > best.len) best <= cur;
        cur.len <= '0;
      end
    end else if (commit) begin
      best    <= fin;
      cur.len <= '0;
    end
  end

  assign best_lo  = TapW'(best.lo);
  assign best_len = LenW'(best.len);
  assign centre   = TapW'(mid);

endmodule

// File: rtl/aib_dll_tap_cal.sv
// DLL tap sweep sequencer: finds the widest passing window and programs its centre.
// Define AIB_DLL_CAL_EARLY_EXIT_EN to stop the sweep once a wide-enough window closes.
module aib_dll_tap_cal
  import aib_cal_pkg::*;
#(
  parameter int TapW         = TAP_W_DEF,
  parameter int SettleCycles = SETTLE_CYCLES_DEF,
  parameter int BlankCycles  = BLANK_CYCLES_DEF,
  parameter int ClearCycles  = CLEAR_CYCLES_DEF,
  parameter int WdogCycles   = WDOG_CYCLES_DEF,
  parameter int MinWin       = MIN_WIN_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  aib_dll_tap_cal_if.master bus
);

`ifdef AIB_DLL_CAL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  localparam int CntMax = (SettleCycles > ClearCycles) ? SettleCycles : ClearCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int BlkW   = (BlankCycles > 0) ? $clog2(BlankCycles + 1) : 1;
  localparam int WdgW   = $clog2(WdogCycles + 1);

  cal_state_e      state;
  logic [CntW-1:0] cnt;
  logic [BlkW-1:0] blk_cnt;
  logic [WdgW-1:0] wdg_cnt;
  logic            res_pass;
  logic            early_q;
  logic [TapW-1:0] dll_tap;
  logic            agent_en, busy, done, fail;
  logic [TapW-1:0] win_lo;
  logic [TapW:0]   win_len;

  logic            stat_any, stat_pass;
  logic            win_clr, win_step, win_commit;
  logic [TapW-1:0] best_lo, centre;
  logic [TapW:0]   best_len;
  logic            final_ok, close_ok;

  assign stat_any   = bus.i_test_pass | bus.i_test_fail | bus.i_test_timeout;
  assign stat_pass  = bus.i_test_pass & ~bus.i_test_fail & ~bus.i_test_timeout;
  assign win_clr    = (state == ST_IDLE) && bus.i_start && !bus.i_abort;
  assign win_step   = (state == ST_EVAL) && !bus.i_abort;
  assign win_commit = (state == ST_CENTER) && !bus.i_abort;

  aib_cal_win_track #(.TapW(TapW), .MinWin(MinWin)) u_win (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .clr       (win_clr),
    .step      (win_step),
    .step_pass (res_pass),
    .commit    (win_commit),
    .tap       (dll_tap),
    .best_lo   (best_lo),
    .best_len  (best_len),
    .centre    (centre),
    .final_ok  (final_ok),
    .close_ok  (close_ok)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      blk_cnt  <= '0;
      wdg_cnt  <= '0;
      res_pass <= 1'b0;
      early_q  <= 1'b0;
      dll_tap  <= '0;
      agent_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      win_lo   <= '0;
      win_len  <= '0;
    end else if (state != ST_IDLE && bus.i_abort) begin
      state    <= ST_IDLE;
      agent_en <= 1'b0;
      dll_tap  <= bus.i_default_tap;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b1;
      early_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (bus.i_start && !bus.i_abort) begin
          dll_tap <= '0;
          done    <= 1'b0;
          fail    <= 1'b0;
          busy    <= 1'b1;
          early_q <= 1'b0;
          cnt     <= CntW'(SettleCycles - 1);
          state   <= ST_SETTLE;
        end
        ST_SETTLE: if (cnt == '0) begin
          agent_en <= 1'b1;
          blk_cnt  <= BlkW'(BlankCycles);
          wdg_cnt  <= WdgW'(WdogCycles - 1);
          state    <= ST_RUN;
        end else begin
          cnt <= cnt - CntW'(1);
        end
        ST_RUN: begin
          if (blk_cnt != '0) blk_cnt <= blk_cnt - BlkW'(1);
          if (wdg_cnt != '0) wdg_cnt <= wdg_cnt - WdgW'(1);
          // Watchdog expiry wins over a status arriving in the same cycle.
          if (wdg_cnt == '0) begin
            res_pass <= 1'b0;
            state    <= ST_EVAL;
          end else if (blk_cnt == '0 && stat_any) begin
            res_pass <= stat_pass;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          agent_en <= 1'b0;
          early_q  <= EarlyExit && !res_pass && close_ok;
          cnt      <= CntW'(ClearCycles - 1);
          state    <= ST_CLEAR;
        end
        ST_CLEAR: if (cnt == '0) begin
          if (dll_tap == '1 || early_q) begin
            state <= ST_CENTER;
          end else begin
            dll_tap <= dll_tap + TapW'(1);
            cnt     <= CntW'(SettleCycles - 1);
            state   <= ST_SETTLE;
          end
        end else begin
          cnt <= cnt - CntW'(1);
        end
        ST_CENTER: begin
          dll_tap <= final_ok ? centre : bus.i_default_tap;
          fail    <= ~final_ok;
          state   <= ST_FINISH;
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          win_lo  <= best_lo;
          win_len <= best_len;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_dll_tap  = dll_tap;
  assign bus.o_agent_en = agent_en;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_fail     = fail;
  assign bus.o_win_lo   = win_lo;
  assign bus.o_win_len  = win_len;

endmodule
